// File: rtl/seven_seg_scan_ctrl_if.sv
// Host-side bundle for seven_seg_scan_ctrl: shadow-buffer writes and the commit handshake.
interface seven_seg_scan_ctrl_if #(
  parameter int AW = 2
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [4:0]    wr_data;
  logic          commit_req;
  logic          commit_ack;

  modport master (
    output wr_valid, wr_addr, wr_data, commit_req,
    input  wr_ready, commit_ack
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, commit_req,
    output wr_ready, commit_ack
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with double-buffered digit codes and frame-aligned commit.
// Optional per-slot blanking interval enabled by defining SCAN_BLANK_EN.
//
// state   | meaning
// S_IDLE  | held in reset; the first edge after release opens the digit-0 slot
// S_BLANK | (SCAN_BLANK_EN only) start of a slot, all anodes off, decoder blank
// S_SCAN  | current digit driven with its active code
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int AW           = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scan_ctrl_if.slave  host,
  output logic [4:0]            dec_code,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic                  frame_start
);

  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PCNT_LAST  = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0]   DIDX_LAST  = AW'(NUM_DIGITS - 1);
  localparam logic [4:0]      CODE_BLANK = 5'h10;

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("NUM_DIGITS must be within 2..8");
  end
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 2");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= TICK_DIV) begin : g_bad_blank
    $error("BLANK_CYCLES must be within 1..TICK_DIV-1");
  end

`ifdef SCAN_BLANK_EN
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BLANK = 2'd1, S_SCAN = 2'd2} state_t;
`else
  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;
`endif

  state_t                  state, state_nxt;
  logic [PW-1:0]           pcnt, pcnt_nxt;
  logic [AW-1:0]           didx, didx_nxt;
  logic                    commit_pending, pending_nxt;
  logic                    commit_ack_q;
  logic [4:0]              shadow [NUM_DIGITS];
  logic [4:0]              active [NUM_DIGITS];

  logic                    slot_start;
  logic                    frame_nxt;
  logic                    do_copy;
  logic [4:0]              code_sel;
  logic [4:0]              dec_nxt;
  logic [NUM_DIGITS-1:0]   anode_nxt;
  logic                    wr_fire;

  assign host.wr_ready   = !commit_pending;
  assign host.commit_ack = commit_ack_q;
  assign wr_fire = host.wr_valid && !commit_pending && (32'(host.wr_addr) < NUM_DIGITS);

  always_comb begin
    slot_start = (state == S_IDLE) || (pcnt == PCNT_LAST);
    pcnt_nxt   = slot_start ? '0 : pcnt + 1'b1;
    didx_nxt   = didx;
    if (state == S_IDLE) begin
      didx_nxt = '0;
    end else if (pcnt == PCNT_LAST) begin
      didx_nxt = (didx == DIDX_LAST) ? '0 : didx + 1'b1;
    end
    frame_nxt = slot_start && (didx_nxt == '0);
    // A request sampled on the wrap edge itself still makes this frame's copy.
    do_copy     = frame_nxt && (commit_pending || host.commit_req);
    pending_nxt = !do_copy && (commit_pending || host.commit_req);

    state_nxt = state;
`ifdef SCAN_BLANK_EN
    if (slot_start) begin
      state_nxt = S_BLANK;
    end else if (state == S_BLANK && pcnt_nxt == BLANK_LAST) begin
      state_nxt = S_SCAN;
    end
`else
    if (slot_start) begin
      state_nxt = S_SCAN;
    end
`endif

    code_sel  = do_copy ? shadow[didx_nxt] : active[didx_nxt];
    dec_nxt   = CODE_BLANK;
    anode_nxt = '1;
    if (state_nxt == S_SCAN) begin
      dec_nxt   = code_sel;
      anode_nxt = ~(NUM_DIGITS'(1) << didx_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pcnt           <= '0;
      didx           <= '0;
      commit_pending <= 1'b0;
      commit_ack_q   <= 1'b0;
      frame_start    <= 1'b0;
      dec_code       <= CODE_BLANK;
      anode_n        <= '1;
    end else begin
      state          <= state_nxt;
      pcnt           <= pcnt_nxt;
      didx           <= didx_nxt;
      commit_pending <= pending_nxt;
      commit_ack_q   <= do_copy;
      frame_start    <= frame_nxt;
      dec_code       <= dec_nxt;
      anode_n        <= anode_nxt;
    end
  end

  // Copy reads the pre-edge shadow, so a write landing on the same edge is not included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= CODE_BLANK;
        active[i] <= CODE_BLANK;
      end
    end else begin
      if (do_copy) begin
        active <= shadow;
      end
      if (wr_fire) begin
        shadow[host.wr_addr] <= host.wr_data;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized scoreboard bench for seven_seg_scan_ctrl (NUM_DIGITS=4, TICK_DIV=4, BLANK_CYCLES=1).
module tb_seven_seg_scan_ctrl;
  localparam int ND    = 4;
  localparam int TD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = ND * TD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    dec_code;
  logic [ND-1:0] anode_n;
  logic          frame_start;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl_if #(.AW(2)) bus ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host(bus.slave),
    .dec_code(dec_code), .anode_n(anode_n), .frame_start(frame_start)
  );

  typedef struct {
    logic [ND-1:0][4:0] codes;
    int                 issue_t;
  } cmt_t;

  int                 errors = 0;
  int                 checks = 0;
  int                 cyc = 0;
  cmt_t               cq[$];
  logic [ND-1:0][4:0] sh_model;
  logic [ND-1:0][4:0] act_model;
  bit                 r_valid = 1'b0;
  int                 r0 = 0;

  int                 t, slot;
  bit                 blank, exp_fs, exp_ack, exp_rdy;
  logic [ND-1:0]      exp_an;
  logic [4:0]         exp_dec;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: expected display follows purely from elapsed cycles since release and committed snapshots.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_anode_n", 32'(anode_n), 32'({ND{1'b1}}));
      check("rst_dec_code", 32'(dec_code), 32'h10);
      check("rst_commit_ack", 32'(bus.commit_ack), 32'h0);
      check("rst_frame_start", 32'(frame_start), 32'h0);
      check("rst_wr_ready", 32'(bus.wr_ready), 32'h1);
      r_valid = 1'b0;
      cq.delete();
      act_model = {ND{5'h10}};
    end else begin
      if (!r_valid) begin
        r0 = cyc;
        r_valid = 1'b1;
      end
      t      = cyc - r0;
      slot   = (t / TD) % ND;
      exp_fs = (t % FRAME) == 0;
      check("frame_start", 32'(frame_start), 32'(exp_fs));
      exp_ack = exp_fs && (cq.size() > 0) && (cq[0].issue_t <= cyc);
      check("commit_ack", 32'(bus.commit_ack), 32'(exp_ack));
      if (bus.commit_ack || exp_ack) begin
        if (cq.size() > 0) begin
          act_model = cq[0].codes;
          cq.pop_front();
        end
      end
`ifdef SCAN_BLANK_EN
      blank = (t % TD) < BC;
`else
      blank = 1'b0;
`endif
      exp_an  = blank ? {ND{1'b1}} : ~(ND'(1) << slot);
      exp_dec = blank ? 5'h10 : act_model[slot];
      check("anode_n", 32'(anode_n), 32'(exp_an));
      check("dec_code", 32'(dec_code), 32'(exp_dec));
      exp_rdy = !((cq.size() > 0) && (cq[0].issue_t <= cyc));
      check("wr_ready", 32'(bus.wr_ready), 32'(exp_rdy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [4:0] d);
    int n;
    n = 0;
    tick();
    while (!bus.wr_ready && n < 100) begin
      tick();
      n++;
    end
    check("wr_ready_wait", 32'(bus.wr_ready), 32'h1);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 2'(a);
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
    sh_model[a]  = d;
  endtask

  // Called just after a rising edge; the request is sampled on the next one.
  task automatic do_commit();
    cmt_t c;
    int   n;
    c.codes   = sh_model;
    c.issue_t = cyc + 1;
    cq.push_back(c);
    bus.commit_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.commit_ack && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("commit_ack_wait", 32'(bus.commit_ack), 32'h1);
    bus.commit_req = 1'b0;
  endtask

  task automatic sync_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_start && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("frame_sync", 32'(frame_start), 32'h1);
  endtask

  initial begin
    bus.wr_valid   = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.commit_req = 1'b0;
    sh_model       = {ND{5'h10}};
    act_model      = {ND{5'h10}};
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle scanning of blank codes.
    repeat (2 * FRAME) tick();

    // Full load and commit.
    do_write(0, 5'h12);
    do_write(1, 5'h13);
    do_write(2, 5'h14);
    do_write(3, 5'h16);
    tick();
    do_commit();
    repeat (FRAME) tick();

    // Uncommitted write must not reach the display.
    do_write(2, 5'h05);
    repeat (3 * FRAME) tick();

    // Request raised in the last cycle of digit 3 is copied on the very next wrap.
    sync_frame();
    repeat (FRAME - 1) @(posedge clk);
    #1;
    do_commit();
    repeat (FRAME) tick();

    // Randomized writes and commits.
    for (int it = 0; it < 8; it++) begin
      int nw;
      nw = int'($urandom_range(1, 4));
      for (int k = 0; k < nw; k++) begin
        do_write(int'($urandom_range(0, ND - 1)), 5'($urandom_range(0, 31)));
      end
      repeat ($urandom_range(0, 20)) tick();
      if ($urandom_range(0, 3) != 0) do_commit();
    end
    repeat (FRAME) tick();

    // Reset while a commit is pending: discarded, no acknowledge afterwards.
    do_write(1, 5'h0A);
    sync_frame();
    @(posedge clk);
    #1;
    cq.push_back('{codes: sh_model, issue_t: cyc + 1});
    bus.commit_req = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n          = 1'b0;
    bus.commit_req = 1'b0;
    sh_model       = {ND{5'h10}};
    #1;
    check("async_rst_anode_n", 32'(anode_n), 32'({ND{1'b1}}));
    check("async_rst_dec_code", 32'(dec_code), 32'h10);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2 * FRAME) tick();

    // Commit with no writes since reset shows the reset contents of shadow.
    do_commit();
    repeat (FRAME) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
